seq_detect_ctrl: RTL and testbench

//  Controller wrapped around a serial pattern-detection datapath. Loads a programmable pattern/mask through
//  a valid/ready config port, arms on start, qualifies the serial bit stream (seq/seq_valid), pulses dout per

---
 rtl/seq_detect_ctrl.sv | 217 +++++++++++++++++++++
 tb/tb_seq_detect_ctrl.sv | 206 ++++++++++++++++++++
 2 files changed

// File: rtl/seq_detect_ctrl.sv
// seq_detect_ctrl: controller around a serial pattern detector.
//
// A pattern/mask/overlap/limit word is loaded through a valid/ready config port.
// The port is ready in IDLE and DONE only. Words offered while ARMED are dropped,
// and cfg_valid is never stalled.
//
// The start pulse arms the detector. While ARMED, each qualified serial bit
// (seq_valid=1) is shifted into a history register; the newest bit lands in bit 0.
// A match pulses dout for one cycle, one cycle after the sampling edge, and
// increments match_cnt. When a nonzero limit is reached, the FSM moves to DONE.
//
// Optional feature: define SEQ_DETECT_TIMEOUT_EN to add the idle-timeout. This adds
// parameter TO_W, input cfg_timeout and output timeout.
//
// Ports:
//   clk          clock, rising edge
//   rst          asynchronous reset, active low
//   cfg_valid    config word valid
//   cfg_ready    config accepted when cfg_valid & cfg_ready
//   cfg_pattern  target pattern, bit 0 = most recent serial bit
//   cfg_mask     1 = compare bit, 0 = don't care
//   cfg_overlap  1 = overlapping matches allowed
//   cfg_limit    matches before DONE, 0 = unlimited
//   cfg_timeout  (optional) idle cycles before timeout, 0 = disabled
//   start        arm / re-arm pulse
//   stop         abort to IDLE pulse, highest priority
//   seq          serial data bit
//   seq_valid    seq qualifier
//   dout         registered 1-cycle match pulse
//   busy         high in ARMED
//   done         high in DONE
//   timeout      (optional) DONE was reached by idle timeout
//   match_cnt    matches since last arm, saturating
module seq_detect_ctrl #(
    parameter int unsigned PAT_W = 4,
    parameter int unsigned CNT_W = 8
`ifdef SEQ_DETECT_TIMEOUT_EN
    ,
    parameter int unsigned TO_W  = 16
`endif
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             cfg_valid,
    output logic             cfg_ready,
    input  logic [PAT_W-1:0] cfg_pattern,
    input  logic [PAT_W-1:0] cfg_mask,
    input  logic             cfg_overlap,
    input  logic [CNT_W-1:0] cfg_limit,
`ifdef SEQ_DETECT_TIMEOUT_EN
    input  logic [TO_W-1:0]  cfg_timeout,
    output logic             timeout,
`endif
    input  logic             start,
    input  logic             stop,
    input  logic             seq,
    input  logic             seq_valid,
    output logic             dout,
    output logic             busy,
    output logic             done,
    output logic [CNT_W-1:0] match_cnt
);

    localparam int unsigned FW = $clog2(PAT_W + 1);
    localparam logic [FW-1:0] FillFull = FW'(PAT_W);

    typedef enum logic [1:0] {StIdle, StArmed, StDone} state_e;

    state_e             state_q, state_d;
    logic [PAT_W-1:0]   pattern_q, pattern_d;
    logic [PAT_W-1:0]   mask_q, mask_d;
    logic               overlap_q, overlap_d;
    logic [CNT_W-1:0]   limit_q, limit_d;
    logic [PAT_W-1:0]   hist_q, hist_d;
    logic [FW-1:0]      fill_q, fill_d;
    logic               dout_q, dout_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;

    logic [PAT_W-1:0]   hist_n;
    logic [FW-1:0]      fill_n;
    logic [CNT_W-1:0]   cnt_n;
    logic               match;
    logic               cfg_hs;

`ifdef SEQ_DETECT_TIMEOUT_EN
    logic [TO_W-1:0]    to_q, to_d;
    logic [TO_W-1:0]    idle_q, idle_d;
    logic [TO_W-1:0]    idle_n;
    logic               timeout_q, timeout_d;
`endif

    assign cfg_ready = (state_q != StArmed);
    assign cfg_hs    = cfg_valid & cfg_ready;

    // Candidate history/fill/count for a sampled bit; match uses the updated history.
    assign hist_n = {hist_q[PAT_W-2:0], seq};
    assign fill_n = (fill_q == FillFull) ? fill_q : fill_q + 1'b1;
    assign match  = (fill_n == FillFull) && (((hist_n ^ pattern_q) & mask_q) == '0);
    assign cnt_n  = (&cnt_q) ? cnt_q : cnt_q + 1'b1;

    always_comb begin
        state_d   = state_q;
        pattern_d = pattern_q;
        mask_d    = mask_q;
        overlap_d = overlap_q;
        limit_d   = limit_q;
        hist_d    = hist_q;
        fill_d    = fill_q;
        cnt_d     = cnt_q;
        dout_d    = 1'b0;
`ifdef SEQ_DETECT_TIMEOUT_EN
        to_d      = to_q;
        idle_d    = idle_q;
        idle_n    = idle_q + 1'b1;
        timeout_d = timeout_q;
`endif

        // Config lands on the same edge as a coincident start, so the arm uses it.
        if (cfg_hs) begin
            pattern_d = cfg_pattern;
            mask_d    = cfg_mask;
            overlap_d = cfg_overlap;
            limit_d   = cfg_limit;
`ifdef SEQ_DETECT_TIMEOUT_EN
            to_d      = cfg_timeout;
`endif
        end

        if (stop) begin
            // match_cnt stays readable until the next arm
            state_d = StIdle;
`ifdef SEQ_DETECT_TIMEOUT_EN
            timeout_d = 1'b0;
`endif
        end else if (start) begin
            state_d = StArmed;
            hist_d  = '0;
            fill_d  = '0;
            cnt_d   = '0;
`ifdef SEQ_DETECT_TIMEOUT_EN
            idle_d    = '0;
            timeout_d = 1'b0;
`endif
        end else if (state_q == StArmed) begin
            if (seq_valid) begin
                hist_d = hist_n;
                fill_d = fill_n;
                if (match) begin
                    dout_d = 1'b1;
                    cnt_d  = cnt_n;
                    // Non-overlap: the next match needs PAT_W fresh bits.
                    if (!overlap_q) begin
                        fill_d = '0;
                    end
                    if ((limit_q != '0) && (cnt_n == limit_q)) begin
                        state_d = StDone;
                    end
                end
            end
`ifdef SEQ_DETECT_TIMEOUT_EN
            // A match in the same cycle wins over the timeout.
            if (seq_valid && match) begin
                idle_d = '0;
            end else begin
                idle_d = idle_n;
                if ((to_q != '0) && (idle_n == to_q)) begin
                    state_d   = StDone;
                    timeout_d = 1'b1;
                end
            end
`endif
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= StIdle;
            pattern_q <= '0;
            mask_q    <= '0;
            overlap_q <= 1'b0;
            limit_q   <= '0;
            hist_q    <= '0;
            fill_q    <= '0;
            dout_q    <= 1'b0;
            cnt_q     <= '0;
`ifdef SEQ_DETECT_TIMEOUT_EN
            to_q      <= '0;
            idle_q    <= '0;
            timeout_q <= 1'b0;
`endif
        end else begin
            state_q   <= state_d;
            pattern_q <= pattern_d;
            mask_q    <= mask_d;
            overlap_q <= overlap_d;
            limit_q   <= limit_d;
            hist_q    <= hist_d;
            fill_q    <= fill_d;
            dout_q    <= dout_d;
            cnt_q     <= cnt_d;
`ifdef SEQ_DETECT_TIMEOUT_EN
            to_q      <= to_d;
            idle_q    <= idle_d;
            timeout_q <= timeout_d;
`endif
        end
    end

    assign dout      = dout_q;
    assign busy      = (state_q == StArmed);
    assign done      = (state_q == StDone);
    assign match_cnt = cnt_q;
`ifdef SEQ_DETECT_TIMEOUT_EN
    assign timeout   = timeout_q;
`endif

endmodule

// File: tb/tb_seq_detect_ctrl.sv
module tb_seq_detect_ctrl;

    localparam int unsigned PAT_W = 4;
    localparam int unsigned CNT_W = 8;

    logic             clk;
    logic             rst;
    logic             cfg_valid;
    logic             cfg_ready;
    logic [PAT_W-1:0] cfg_pattern;
    logic [PAT_W-1:0] cfg_mask;
    logic             cfg_overlap;
    logic [CNT_W-1:0] cfg_limit;
    logic             start;
    logic             stop;
    logic             seq;
    logic             seq_valid;
    logic             dout;
    logic             busy;
    logic             done;
    logic [CNT_W-1:0] match_cnt;

    int unsigned errors = 0;
    int unsigned checks = 0;
    logic        exp_q[$];

    seq_detect_ctrl #(
        .PAT_W (PAT_W),
        .CNT_W (CNT_W)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .cfg_valid   (cfg_valid),
        .cfg_ready   (cfg_ready),
        .cfg_pattern (cfg_pattern),
        .cfg_mask    (cfg_mask),
        .cfg_overlap (cfg_overlap),
        .cfg_limit   (cfg_limit),
        .start       (start),
        .stop        (stop),
        .seq         (seq),
        .seq_valid   (seq_valid),
        .dout        (dout),
        .busy        (busy),
        .done        (done),
        .match_cnt   (match_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic load_cfg(input logic [PAT_W-1:0] p, input logic [PAT_W-1:0] m,
                            input logic ov, input logic [CNT_W-1:0] lim);
        cfg_valid   = 1'b1;
        cfg_pattern = p;
        cfg_mask    = m;
        cfg_overlap = ov;
        cfg_limit   = lim;
        @(negedge clk);
        cfg_valid   = 1'b0;
    endtask

    task automatic arm();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check("arm_busy", 32'(busy), 32'd1);
        check("arm_cnt", 32'(match_cnt), 32'd0);
    endtask

    // Scoreboard: expected dout for each driven bit is queued, then popped after the edge.
    task automatic send_bit(input logic b, input logic exp, input logic do_stop);
        seq       = b;
        seq_valid = 1'b1;
        stop      = do_stop;
        exp_q.push_back(exp);
        @(negedge clk);
        seq_valid = 1'b0;
        stop      = 1'b0;
        check("dout", 32'(dout), 32'(exp_q.pop_front()));
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            exp_q.push_back(1'b0);
            @(negedge clk);
            check("dout_idle", 32'(dout), 32'(exp_q.pop_front()));
        end
    endtask

    initial begin
        rst         = 1'b0;
        cfg_valid   = 1'b0;
        cfg_pattern = '0;
        cfg_mask    = '0;
        cfg_overlap = 1'b0;
        cfg_limit   = '0;
        start       = 1'b0;
        stop        = 1'b0;
        seq         = 1'b0;
        seq_valid   = 1'b0;

        // Reset state
        #12;
        check("rst_dout", 32'(dout), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_cnt", 32'(match_cnt), 32'd0);
        check("rst_ready", 32'(cfg_ready), 32'd1);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);

        // Non-overlapping 1011 over 1,0,1,1,0,1,1
        load_cfg(4'b1011, 4'hF, 1'b0, 8'd0);
        arm();
        check("armed_ready", 32'(cfg_ready), 32'd0);
        send_bit(1, 0, 0); send_bit(0, 0, 0); send_bit(1, 0, 0); send_bit(1, 1, 0);
        send_bit(0, 0, 0); send_bit(1, 0, 0); send_bit(1, 0, 0);
        check("t2_cnt", 32'(match_cnt), 32'd1);
        stop = 1'b1; @(negedge clk); stop = 1'b0;

        // Overlapping: second match on the 7th bit
        load_cfg(4'b1011, 4'hF, 1'b1, 8'd0);
        arm();
        send_bit(1, 0, 0); send_bit(0, 0, 0); send_bit(1, 0, 0); send_bit(1, 1, 0);
        send_bit(0, 0, 0); send_bit(1, 0, 0); send_bit(1, 1, 0);
        check("t3_cnt", 32'(match_cnt), 32'd2);
        stop = 1'b1; @(negedge clk); stop = 1'b0;

        // Limit of 2 reaches DONE, later bits ignored
        load_cfg(4'hF, 4'hF, 1'b1, 8'd2);
        arm();
        send_bit(1, 0, 0); send_bit(1, 0, 0); send_bit(1, 0, 0); send_bit(1, 1, 0);
        check("t4_busy_mid", 32'(busy), 32'd1);
        send_bit(1, 1, 0);
        check("t4_done", 32'(done), 32'd1);
        check("t4_busy", 32'(busy), 32'd0);
        send_bit(1, 0, 0); send_bit(1, 0, 0);
        check("t4_cnt", 32'(match_cnt), 32'd2);
        check("t4_ready", 32'(cfg_ready), 32'd1);

        // mask=0 matches every bit after fill; then async reset mid-ARMED (history ..101)
        load_cfg(4'h0, 4'h0, 1'b1, 8'd0);
        arm();
        send_bit(1, 0, 0); send_bit(0, 0, 0); send_bit(1, 0, 0); send_bit(1, 1, 0);
        send_bit(0, 1, 0); send_bit(1, 1, 0);
        check("t1_cnt_pre", 32'(match_cnt), 32'd3);
        rst = 1'b0;
        #1;
        check("t1_dout", 32'(dout), 32'd0);
        check("t1_busy", 32'(busy), 32'd0);
        check("t1_done", 32'(done), 32'd0);
        check("t1_cnt", 32'(match_cnt), 32'd0);
        check("t1_ready", 32'(cfg_ready), 32'd1);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);

        // seq_valid gaps of 3 cycles
        load_cfg(4'b1011, 4'hF, 1'b0, 8'd0);
        arm();
        send_bit(1, 0, 0); idle(3); send_bit(0, 0, 0); idle(3);
        send_bit(1, 0, 0); idle(3); send_bit(1, 1, 0); idle(3);
        send_bit(0, 0, 0); idle(3); send_bit(1, 0, 0); idle(3);
        send_bit(1, 0, 0);
        check("t5_cnt", 32'(match_cnt), 32'd1);
        stop = 1'b1; @(negedge clk); stop = 1'b0;

        // stop together with a matching bit: no pulse, count preserved
        load_cfg(4'hF, 4'hF, 1'b1, 8'd0);
        arm();
        send_bit(1, 0, 0); send_bit(1, 0, 0); send_bit(1, 0, 0); send_bit(1, 1, 0);
        send_bit(1, 0, 1);
        check("t6_busy", 32'(busy), 32'd0);
        check("t6_done", 32'(done), 32'd0);
        check("t6_cnt", 32'(match_cnt), 32'd1);
        check("t6_ready", 32'(cfg_ready), 32'd1);

        // Config offered while ARMED is dropped; old pattern still matches
        arm();
        cfg_valid   = 1'b1;
        cfg_pattern = 4'h0;
        cfg_mask    = 4'hF;
        #1;
        check("t6_ready_armed", 32'(cfg_ready), 32'd0);
        @(negedge clk);
        cfg_valid = 1'b0;
        send_bit(1, 0, 0); send_bit(1, 0, 0); send_bit(1, 0, 0); send_bit(1, 1, 0);
        check("t6_cnt_old_cfg", 32'(match_cnt), 32'd1);
        idle(1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
